// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory-port arbiter: reset/boolean levels,
// two-bit FSM state codes and transaction-owner codes.
package mem_port_arbiter_pkg;

  localparam logic RST_ACTIVE = 1'b1;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select between fetch and load/store, zero-latency; the streak counter
// bounds how many data grants may pass a waiting fetch before it is forced through.
module mem_arb_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic i_vld_i,
  input  logic d_vld_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          starved;

  assign starved   = (streak_q == SW'(STARVE_MAX));
  assign grant_d_o = arb_en_i & d_vld_i & (~i_vld_i | ~starved);
  assign grant_i_o = arb_en_i & i_vld_i & ~grant_d_o;

  // Only a data grant that actually passes a waiting fetch extends the streak.
  always_comb begin
    streak_d = streak_q;
    if (grant_d_o && i_vld_i) begin
      if (!starved) streak_d = streak_q + SW'(1);
    end else if (grant_i_o || grant_d_o) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) streak_q <= '0;
    else                     streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight;
// 0-wait memory gives accept->rsp pulse of 3 cycles, memory stalls hold the request stable.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  output logic                i_rsp_err,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                d_rsp_err,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_we,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  output logic [DATA_W-1:0]   m_req_wdata,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rsp_data
);

  localparam int TW = $clog2(TIMEOUT + 2);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                we;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   wdata;
  } mreq_t;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  mreq_t             req_q, req_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              i_rsp_vld_q, i_rsp_vld_d;
  logic              d_rsp_vld_q, d_rsp_vld_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              arb_en, grant_i, grant_d, timed_out;

  mem_arb_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clk       (clk),
    .reset     (reset),
    .arb_en_i  (arb_en),
    .i_vld_i   (i_req_valid),
    .d_vld_i   (d_req_valid),
    .grant_i_o (grant_i),
    .grant_d_o (grant_d)
  );

  assign timed_out = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) state_q <= ST_IDLE;
    else                     state_q <= state_d;
  end

  // A response arriving in the timeout cycle wins over the error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant_i || grant_d) state_d = ST_ISSUE;
      ST_ISSUE: if (m_req_ready) state_d = ST_WAIT;
      ST_WAIT:  if (m_rsp_valid || timed_out) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arb_en      = (state_q == ST_IDLE) && (reset != RST_ACTIVE);
    i_req_ready = grant_i;
    d_req_ready = grant_d;
    m_req_valid = (state_q == ST_ISSUE);
  end

  always_comb begin
    owner_d     = owner_q;
    req_d       = req_q;
    timer_d     = timer_q;
    i_rsp_vld_d = FALSE;
    d_rsp_vld_d = FALSE;
    rsp_err_d   = FALSE;
    rsp_dat_d   = '0;
    if (grant_d) begin
      owner_d     = OWN_D;
      req_d.addr  = d_req_addr;
      req_d.we    = d_req_we;
      req_d.wstrb = d_req_wstrb;
      req_d.wdata = d_req_wdata;
    end else if (grant_i) begin
      owner_d     = OWN_I;
      req_d.addr  = i_req_addr;
      req_d.we    = FALSE;
      req_d.wstrb = '0;
      req_d.wdata = '0;
    end
    if (state_q == ST_ISSUE) timer_d = '0;
    if (state_q == ST_WAIT) begin
      timer_d = timer_q + TW'(1);
      if (m_rsp_valid || timed_out) begin
        i_rsp_vld_d = (owner_q == OWN_I);
        d_rsp_vld_d = (owner_q == OWN_D);
        rsp_err_d   = ~m_rsp_valid;
        rsp_dat_d   = m_rsp_valid ? m_rsp_data : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset == RST_ACTIVE) begin
      owner_q     <= OWN_I;
      req_q       <= '0;
      timer_q     <= '0;
      i_rsp_vld_q <= FALSE;
      d_rsp_vld_q <= FALSE;
      rsp_err_q   <= FALSE;
      rsp_dat_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      req_q       <= req_d;
      timer_q     <= timer_d;
      i_rsp_vld_q <= i_rsp_vld_d;
      d_rsp_vld_q <= d_rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign m_req_addr  = req_q.addr;
  assign m_req_we    = req_q.we;
  assign m_req_wstrb = req_q.wstrb;
  assign m_req_wdata = req_q.wdata;

  assign i_rsp_valid = i_rsp_vld_q;
  assign i_rsp_err   = i_rsp_vld_q & rsp_err_q;
  assign i_rsp_data  = i_rsp_vld_q ? rsp_dat_q : '0;
  assign d_rsp_valid = d_rsp_vld_q;
  assign d_rsp_err   = d_rsp_vld_q & rsp_err_q;
  assign d_rsp_data  = d_rsp_vld_q ? rsp_dat_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8)
// against an arbitration/response model kept in the bench.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_wstrb;
  logic        m_req_valid, m_req_ready, m_req_we, m_rsp_valid;
  logic [31:0] m_req_addr, m_req_wdata, m_rsp_data;
  logic [3:0]  m_req_wstrb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wstrb(m_req_wstrb), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data)
  );

  logic        s_i_rdy, s_d_rdy, s_i_rv, s_i_re, s_d_rv, s_d_re, s_m_v, s_m_we;
  logic [31:0] s_i_rd, s_d_rd, s_m_a, s_m_wd;
  logic [3:0]  s_m_ws;

  // Reference-model state
  int          streak;
  logic        ip, dp, dwe, ew_i, ew_d;
  logic [31:0] ia, da, dwd, rd;
  logic [3:0]  dws;
  logic        rsp_due, e_own_d, e_err;
  logic [31:0] e_dat, e_a, e_wd;
  logic        e_we;
  logic [3:0]  e_ws;
  logic [9:0]  g_exp;
  int          stall, lat, last;

  // Inputs change at posedge+1, outputs are captured at posedge+4.
  task automatic cyc();
    #3;
    s_i_rdy = i_req_ready; s_d_rdy = d_req_ready;
    s_i_rv = i_rsp_valid; s_i_rd = i_rsp_data; s_i_re = i_rsp_err;
    s_d_rv = d_rsp_valid; s_d_rd = d_rsp_data; s_d_re = d_rsp_err;
    s_m_v = m_req_valid; s_m_a = m_req_addr; s_m_we = m_req_we;
    s_m_ws = m_req_wstrb; s_m_wd = m_req_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_rsp();
    if (rsp_due) begin
      chk("rsp_i_vld", s_i_rv, !e_own_d);
      chk("rsp_d_vld", s_d_rv, e_own_d);
      chk("rsp_dat", e_own_d ? s_d_rd : s_i_rd, e_dat);
      chk("rsp_err", e_own_d ? s_d_re : s_i_re, e_err);
      rsp_due = 1'b0;
    end else begin
      chk("rsp_idle", {s_i_rv, s_d_rv}, 2'b00);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h0; d_req_we = 1'b0;
    d_req_wstrb = 4'h0; d_req_wdata = 32'h0;
    m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = 32'h0;
    rsp_due = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, requests held valid to show ready stays low
    cyc(); cyc();
    chk("rst_ready", {s_i_rdy, s_d_rdy}, 2'b00);
    chk("rst_rsp", {s_i_rv, s_d_rv, s_i_re, s_d_re}, 4'h0);
    chk("rst_mreq", {s_m_v, s_m_we, s_m_ws}, 6'h0);
    chk("rst_maddr", {s_m_a, s_m_wd}, 64'h0);
    reset = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;

    // 1: lone fetch, 0-wait memory
    i_req_valid = 1'b1; i_req_addr = 32'h100; m_req_ready = 1'b1;
    cyc();
    chk("t1_i_rdy", s_i_rdy, 1'b1);
    chk("t1_d_rdy", s_d_rdy, 1'b0);
    i_req_valid = 1'b0;
    cyc();
    chk("t1_m_v", s_m_v, 1'b1);
    chk("t1_m_a", s_m_a, 32'h100);
    chk("t1_m_wr", {s_m_we, s_m_ws, s_m_wd}, 37'h0);
    m_rsp_valid = 1'b1; m_rsp_data = 32'h13;
    cyc();
    chk("t1_early", s_i_rv, 1'b0);
    m_rsp_valid = 1'b0; m_rsp_data = 32'h0;
    cyc();
    chk("t1_rv", s_i_rv, 1'b1);
    chk("t1_rd", s_i_rd, 32'h13);
    chk("t1_re", s_i_re, 1'b0);
    chk("t1_d_rv", s_d_rv, 1'b0);
    cyc();
    chk("t1_pulse", s_i_rv, 1'b0);

    // 2: store stalled five cycles by the memory
    d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_we = 1'b1;
    d_req_wstrb = 4'hF; d_req_wdata = 32'hDEADBEEF; m_req_ready = 1'b0;
    cyc();
    chk("t2_d_rdy", s_d_rdy, 1'b1);
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0; d_req_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_stall_v", s_m_v, 1'b1);
      chk("t2_stall_a", s_m_a, 32'h200);
      chk("t2_stall_w", {s_m_we, s_m_ws, s_m_wd}, {1'b1, 4'hF, 32'hDEADBEEF});
    end
    m_req_ready = 1'b1;
    cyc();
    chk("t2_acc_v", s_m_v, 1'b1);
    m_req_ready = 1'b0; m_rsp_valid = 1'b1;
    cyc();
    chk("t2_wait", s_d_rv, 1'b0);
    m_rsp_valid = 1'b0;
    cyc();
    chk("t2_rv", {s_d_rv, s_d_re, s_i_rv}, 3'b100);
    cyc();
    chk("t2_once", s_d_rv, 1'b0);

    // 3: both valid every cycle -> D,D,D,D,I,D,D,D,D,I
    g_exp = 10'b1111011110;
    i_req_valid = 1'b1; i_req_addr = 32'h104;
    d_req_valid = 1'b1; d_req_addr = 32'h204;
    m_req_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      m_rsp_valid = 1'b0;
      cyc();
      chk("t3_grant_d", s_d_rdy, g_exp[9-t]);
      chk("t3_one_rdy", s_i_rdy ^ s_d_rdy, 1'b1);
      cyc();
      m_rsp_valid = 1'b1;
      cyc();
    end
    m_rsp_valid = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
    cyc();
    chk("t3_last_i", {s_i_rv, s_d_rv}, 2'b10);

    // 4: load with no memory answer -> error 8 cycles after entering WAIT
    d_req_valid = 1'b1; d_req_addr = 32'h300;
    cyc();
    chk("t4_d_rdy", s_d_rdy, 1'b1);
    d_req_valid = 1'b0;
    cyc();
    m_req_ready = 1'b0;
    for (int w = 0; w < 8; w++) begin
      cyc();
      chk("t4_wait", s_d_rv, 1'b0);
    end
    i_req_valid = 1'b1; i_req_addr = 32'h500;
    cyc();
    chk("t4_to_v", s_d_rv, 1'b1);
    chk("t4_to_err", s_d_re, 1'b1);
    chk("t4_to_dat", s_d_rd, 32'h0);
    chk("t4_idle", s_i_rdy, 1'b1);
    i_req_valid = 1'b0; m_req_ready = 1'b1;
    cyc();

    // 5: reset while in WAIT, then a late answer
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("t5_ctl", {s_i_rdy, s_d_rdy, s_i_rv, s_d_rv, s_i_re, s_d_re, s_m_v}, 7'h0);
    chk("t5_dat", {s_m_a, s_i_rd}, 64'h0);
    m_rsp_valid = 1'b1; m_rsp_data = 32'hBAD;
    cyc();
    chk("t5_late_m", s_m_v, 1'b0);
    m_rsp_valid = 1'b0;
    cyc();
    chk("t5_ignored", {s_i_rv, s_d_rv}, 2'b00);

    // 6: response lands in the timeout cycle
    d_req_valid = 1'b1; d_req_addr = 32'h400;
    cyc();
    chk("t6_d_rdy", s_d_rdy, 1'b1);
    d_req_valid = 1'b0;
    cyc();
    for (int w = 0; w < 8; w++) begin
      m_rsp_valid = (w == 7); m_rsp_data = 32'hCAFEF00D;
      cyc();
    end
    m_rsp_valid = 1'b0;
    cyc();
    chk("t6_v", s_d_rv, 1'b1);
    chk("t6_err", s_d_re, 1'b0);
    chk("t6_dat", s_d_rd, 32'hCAFEF00D);

    // Randomized traffic against the reference model
    streak = 0; ip = 1'b0; dp = 1'b0;
    ia = '0; da = '0; dwe = 1'b0; dws = '0; dwd = '0;
    for (int r = 0; r < 300; r++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1'b1; ia = $urandom;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1'b1; da = $urandom; dwe = 1'($urandom_range(0, 1));
        dws = 4'($urandom); dwd = $urandom;
      end
      i_req_valid = ip; i_req_addr = ia;
      d_req_valid = dp; d_req_addr = da; d_req_we = dwe;
      d_req_wstrb = dws; d_req_wdata = dwd;
      m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = $urandom;
      ew_d = dp && (!ip || streak != 4);
      ew_i = ip && !ew_d;
      cyc();
      chk_rsp();
      chk("rnd_i_rdy", s_i_rdy, ew_i);
      chk("rnd_d_rdy", s_d_rdy, ew_d);
      if (!ip && !dp) continue;
      streak = (ew_d && ip) ? ((streak < 4) ? streak + 1 : 4) : 0;
      e_own_d = ew_d;
      if (ew_d) begin
        e_a = da; e_we = dwe; e_ws = dws; e_wd = dwd; dp = 1'b0;
      end else begin
        e_a = ia; e_we = 1'b0; e_ws = 4'h0; e_wd = 32'h0; ip = 1'b0;
      end
      i_req_valid = ip; d_req_valid = dp;
      stall = $urandom_range(0, 3);
      for (int k = 0; k <= stall; k++) begin
        m_req_ready = (k == stall);
        cyc();
        chk_rsp();
        chk("rnd_m_v", s_m_v, 1'b1);
        chk("rnd_m_a", s_m_a, e_a);
        chk("rnd_m_w", {s_m_we, s_m_ws, s_m_wd}, {e_we, e_ws, e_wd});
        chk("rnd_busy_rdy", {s_i_rdy, s_d_rdy}, 2'b00);
      end
      m_req_ready = 1'b0;
      lat = $urandom_range(0, 10);
      last = (lat < 8) ? lat : 7;
      rd = $urandom;
      for (int w = 0; w <= last; w++) begin
        m_rsp_valid = (w == lat);
        m_rsp_data = (w == lat) ? rd : $urandom;
        cyc();
        chk_rsp();
        chk("rnd_wait_m_v", s_m_v, 1'b0);
      end
      m_rsp_valid = 1'b0;
      rsp_due = 1'b1;
      e_dat = (lat < 8) ? rd : 32'h0;
      e_err = (lat >= 8);
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0; m_rsp_valid = 1'b0;
    cyc();
    chk_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
